// File: rtl/pcie_wb_sequencer_if.sv
// Bus bundle for pcie_wb_sequencer: converter-side and target-side Wishbone master signals.
interface pcie_wb_sequencer_if #(
   parameter int WB_ADDRW = 16
);
   logic                c_stb_o;
   logic                c_we_o;
   logic [WB_ADDRW-1:0] c_adr_o;
   logic [31:0]         c_dat_o;
   logic                c_ack_i;
   logic [31:0]         c_dat_i;
   logic                t_stb_o;
   logic                t_we_o;
   logic [WB_ADDRW-1:0] t_adr_o;
   logic [31:0]         t_dat_o;
   logic                t_ack_i;
   logic [31:0]         t_dat_i;

   modport master (
      output c_stb_o, c_we_o, c_adr_o, c_dat_o, input c_ack_i, c_dat_i,
      output t_stb_o, t_we_o, t_adr_o, t_dat_o, input t_ack_i, t_dat_i
   );
   modport slave (
      input c_stb_o, c_we_o, c_adr_o, c_dat_o, output c_ack_i, c_dat_i,
      input t_stb_o, t_we_o, t_adr_o, t_dat_o, output t_ack_i, t_dat_i
   );
endinterface

// File: rtl/pcie_wb_sequencer.sv
// Polls the PCIe/Wishbone converter, executes fetched requests on the target bus, posts read responses.
// Optional target-ack watchdog enabled by defining PCIE_WB_SEQ_TIMEOUT_EN.
module pcie_wb_sequencer #(
   parameter int                  WB_ADDRW      = 16,
   parameter logic [WB_ADDRW-1:0] CONV_BASE     = 16'h0000,
   parameter int                  POLL_INTERVAL = 64,
   parameter int                  TGT_TIMEOUT   = 1024,
   parameter logic [31:0]         ERR_DATA      = 32'hDEADBEEF
) (
   input  logic                clk,
   input  logic                rst,
   pcie_wb_sequencer_if.master bus,
   output logic                busy,
   output logic                tgt_timeout_err,
   output logic [15:0]         req_count
);
   localparam int PW = $clog2(POLL_INTERVAL + 1);

   typedef enum logic [3:0] {
      IDLE, POLL, RD_DATA, RD_CTRL, EXEC, CHK_FIFO, WR_RESP_DATA, WR_RESP_CTRL, DONE
   } state_t;

   state_t              state_q, state_n;
   logic [PW-1:0]       poll_q, poll_n;
   logic                c_stb_q, c_stb_n, c_we_q, c_we_n;
   logic [WB_ADDRW-1:0] c_adr_q, c_adr_n;
   logic [31:0]         c_dat_q, c_dat_n;
   logic                t_stb_q, t_stb_n, t_we_q, t_we_n;
   logic [WB_ADDRW-1:0] t_adr_q, t_adr_n;
   logic [31:0]         t_dat_q, t_dat_n;
   logic [31:0]         data_q, data_n, ctrl_q, ctrl_n, rdata_q, rdata_n;
   logic [15:0]         cnt_q, cnt_n;
   logic                is_read;

   function automatic logic [WB_ADDRW-1:0] conv_adr(input logic [1:0] idx);
      return CONV_BASE | WB_ADDRW'({idx, 2'b00});
   endfunction

   // Both type bits set executes as a write; only a pure read request returns data.
   assign is_read = ctrl_q[29] & ~ctrl_q[30];

`ifdef PCIE_WB_SEQ_TIMEOUT_EN
   localparam int WDW = $clog2(TGT_TIMEOUT + 1);
   logic [WDW-1:0] wd_q, wd_n;
   logic           err_q, err_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_n;
         err_q <= err_n;
      end
   end
   assign tgt_timeout_err = err_q;
`else
   assign tgt_timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         poll_q  <= PW'(POLL_INTERVAL);
         c_stb_q <= 1'b0;  c_we_q <= 1'b0;  c_adr_q <= '0;  c_dat_q <= '0;
         t_stb_q <= 1'b0;  t_we_q <= 1'b0;  t_adr_q <= '0;  t_dat_q <= '0;
         data_q  <= '0;    ctrl_q <= '0;    rdata_q <= '0;  cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         poll_q  <= poll_n;
         c_stb_q <= c_stb_n;  c_we_q <= c_we_n;  c_adr_q <= c_adr_n;  c_dat_q <= c_dat_n;
         t_stb_q <= t_stb_n;  t_we_q <= t_we_n;  t_adr_q <= t_adr_n;  t_dat_q <= t_dat_n;
         data_q  <= data_n;   ctrl_q <= ctrl_n;  rdata_q <= rdata_n;  cnt_q   <= cnt_n;
      end
   end

   // Each bus state: first cycle (stb low) issues the access, the ack cycle drops stb and moves on.
   always_comb begin
      state_n = state_q;  poll_n = poll_q;
      c_stb_n = c_stb_q;  c_we_n = c_we_q;  c_adr_n = c_adr_q;  c_dat_n = c_dat_q;
      t_stb_n = t_stb_q;  t_we_n = t_we_q;  t_adr_n = t_adr_q;  t_dat_n = t_dat_q;
      data_n  = data_q;   ctrl_n = ctrl_q;  rdata_n = rdata_q;  cnt_n   = cnt_q;
`ifdef PCIE_WB_SEQ_TIMEOUT_EN
      wd_n  = wd_q;
      err_n = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (poll_q == '0) state_n = POLL;
            else              poll_n  = poll_q - 1'b1;
         end
         POLL: begin
            if (!c_stb_q) begin
               c_stb_n = 1'b1;  c_we_n = 1'b0;  c_adr_n = conv_adr(2'd3);
            end else if (bus.c_ack_i) begin
               c_stb_n = 1'b0;
               if (bus.c_dat_i[1]) begin
                  state_n = RD_DATA;
               end else begin
                  state_n = IDLE;
                  poll_n  = PW'(POLL_INTERVAL);
               end
            end
         end
         RD_DATA: begin
            if (!c_stb_q) begin
               c_stb_n = 1'b1;  c_we_n = 1'b0;  c_adr_n = conv_adr(2'd0);
            end else if (bus.c_ack_i) begin
               c_stb_n = 1'b0;  data_n = bus.c_dat_i;  state_n = RD_CTRL;
            end
         end
         RD_CTRL: begin
            if (!c_stb_q) begin
               c_stb_n = 1'b1;  c_we_n = 1'b0;  c_adr_n = conv_adr(2'd1);
            end else if (bus.c_ack_i) begin
               c_stb_n = 1'b0;
               ctrl_n  = bus.c_dat_i;
               state_n = (bus.c_dat_i[30] | bus.c_dat_i[29]) ? EXEC : DONE;
            end
         end
         EXEC: begin
            if (!t_stb_q) begin
               t_stb_n = 1'b1;
               t_we_n  = ctrl_q[30];
               t_adr_n = ctrl_q[WB_ADDRW-1:0];
               t_dat_n = data_q;
`ifdef PCIE_WB_SEQ_TIMEOUT_EN
               wd_n    = WDW'(TGT_TIMEOUT - 1);
`endif
            end else if (bus.t_ack_i) begin
               t_stb_n = 1'b0;
               if (is_read) begin
                  rdata_n = bus.t_dat_i;  state_n = CHK_FIFO;
               end else begin
                  state_n = DONE;
               end
`ifdef PCIE_WB_SEQ_TIMEOUT_EN
            end else if (wd_q == '0) begin
               t_stb_n = 1'b0;
               err_n   = 1'b1;
               if (is_read) begin
                  rdata_n = ERR_DATA;  state_n = CHK_FIFO;
               end else begin
                  state_n = DONE;
               end
            end else begin
               wd_n = wd_q - 1'b1;
`endif
            end
         end
         CHK_FIFO: begin
            if (!c_stb_q) begin
               c_stb_n = 1'b1;  c_we_n = 1'b0;  c_adr_n = conv_adr(2'd3);
            end else if (bus.c_ack_i) begin
               c_stb_n = 1'b0;
               if (!bus.c_dat_i[4]) state_n = WR_RESP_DATA;
            end
         end
         WR_RESP_DATA: begin
            if (!c_stb_q) begin
               c_stb_n = 1'b1;  c_we_n = 1'b1;  c_adr_n = conv_adr(2'd0);  c_dat_n = rdata_q;
            end else if (bus.c_ack_i) begin
               c_stb_n = 1'b0;  state_n = WR_RESP_CTRL;
            end
         end
         WR_RESP_CTRL: begin
            if (!c_stb_q) begin
               c_stb_n = 1'b1;  c_we_n = 1'b1;  c_adr_n = conv_adr(2'd1);
               c_dat_n = {3'b100, ctrl_q[28:0]};
            end else if (bus.c_ack_i) begin
               c_stb_n = 1'b0;  state_n = DONE;
            end
         end
         DONE: begin
            cnt_n   = cnt_q + 16'd1;
            state_n = POLL;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.c_stb_o = c_stb_q;
   assign bus.c_we_o  = c_we_q;
   assign bus.c_adr_o = c_adr_q;
   assign bus.c_dat_o = c_dat_q;
   assign bus.t_stb_o = t_stb_q;
   assign bus.t_we_o  = t_we_q;
   assign bus.t_adr_o = t_adr_q;
   assign bus.t_dat_o = t_dat_q;
   assign busy        = (state_q != IDLE);
   assign req_count   = cnt_q;

   logic unused_cfg;
   assign unused_cfg = ^{ctrl_q[31], ERR_DATA, TGT_TIMEOUT};
endmodule

// File: tb/tb_pcie_wb_sequencer.sv
// Directed bench for pcie_wb_sequencer: converter/target responder models with scoreboard queues.
module tb_pcie_wb_sequencer;
   localparam int          AW   = 16;
   localparam logic [15:0] BASE = 16'h0100;
   localparam int          PI   = 8;
   localparam int          TO   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pcie_wb_sequencer_if #(.WB_ADDRW(AW)) bus ();
   logic        busy, err;
   logic [15:0] req_count;

   pcie_wb_sequencer #(
      .WB_ADDRW(AW), .CONV_BASE(BASE), .POLL_INTERVAL(PI),
      .TGT_TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .busy(busy), .tgt_timeout_err(err), .req_count(req_count)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   typedef struct packed { logic [31:0] data; logic [31:0] ctrl; } req_t;
   typedef struct packed { logic we; logic [15:0] adr; logic [31:0] dat; logic [31:0] rdata; } tgt_t;
   typedef struct packed { logic [1:0] idx; logic [31:0] dat; } cw_t;

   req_t pend_q[$];
   tgt_t tgt_q[$];
   cw_t  cw_q[$];

   logic fifo_full  = 1'b0;
   logic tgt_ack_en = 1'b1;
   int   conv_wr_cnt = 0;
   int   rd_data_cnt = 0;
   int   tstb_len = 0;
   int   tstb_last = 0;
   logic saw_idle = 1'b0;

   // Converter responder: one-cycle ack latency, pending-request FIFO, status word.
   always @(posedge clk) begin
      if (rst) begin
         bus.c_ack_i <= 1'b0;
      end else if (bus.c_stb_o && !bus.c_ack_i) begin
         bus.c_ack_i <= 1'b1;
         chk("conv_base", {16'h0, bus.c_adr_o & ~16'h000C}, {16'h0, BASE});
         if (bus.c_we_o) begin
            conv_wr_cnt++;
            chk("conv_wr_expected", {31'h0, cw_q.size() != 0}, 32'h1);
            if (cw_q.size() != 0) begin
               cw_t e;
               e = cw_q.pop_front();
               chk("conv_wr_idx", {30'h0, bus.c_adr_o[3:2]}, {30'h0, e.idx});
               chk("conv_wr_dat", bus.c_dat_o, e.dat);
            end
         end else begin
            case (bus.c_adr_o[3:2])
               2'd0: begin
                  rd_data_cnt++;
                  bus.c_dat_i <= (pend_q.size() != 0) ? pend_q[0].data : 32'h0;
               end
               2'd1: begin
                  if (pend_q.size() != 0) bus.c_dat_i <= pend_q.pop_front().ctrl;
                  else                    bus.c_dat_i <= 32'h0;
               end
               2'd3: bus.c_dat_i <= {27'h0, fifo_full, 2'b00, pend_q.size() != 0, 1'b0};
               default: bus.c_dat_i <= 32'h0;
            endcase
         end
      end else begin
         bus.c_ack_i <= 1'b0;
      end
   end

   // Target responder: checks each transaction against the expected queue.
   always @(posedge clk) begin
      if (rst) begin
         bus.t_ack_i <= 1'b0;
      end else if (bus.t_stb_o && !bus.t_ack_i && tgt_ack_en) begin
         bus.t_ack_i <= 1'b1;
         chk("tgt_expected", {31'h0, tgt_q.size() != 0}, 32'h1);
         if (tgt_q.size() != 0) begin
            tgt_t e;
            e = tgt_q.pop_front();
            chk("tgt_we",  {31'h0, bus.t_we_o}, {31'h0, e.we});
            chk("tgt_adr", {16'h0, bus.t_adr_o}, {16'h0, e.adr});
            chk("tgt_dat", bus.t_dat_o, e.dat);
            bus.t_dat_i <= e.rdata;
         end
      end else begin
         bus.t_ack_i <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (bus.t_stb_o) begin
         tstb_len++;
      end else if (tstb_len != 0) begin
         tstb_last = tstb_len;
         tstb_len  = 0;
      end
   end

   always @(negedge clk) if (!busy) saw_idle = 1'b1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_count(input logic [15:0] n, input int budget);
      int i = 0;
      while (req_count !== n && i < budget) begin @(negedge clk); i++; end
      chk("req_count", {16'h0, req_count}, {16'h0, n});
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while (busy !== 1'b0 && i < budget) begin @(negedge clk); i++; end
      chk("idle", {31'h0, busy}, 32'h0);
   endtask

   task automatic post_write(input logic [31:0] data, input logic [31:0] ctrl);
      pend_q.push_back(req_t'{data: data, ctrl: ctrl});
      tgt_q.push_back(tgt_t'{we: 1'b1, adr: ctrl[15:0], dat: data, rdata: 32'h0});
   endtask

   task automatic post_read(input logic [31:0] data, input logic [31:0] ctrl, input logic [31:0] rd);
      pend_q.push_back(req_t'{data: data, ctrl: ctrl});
      tgt_q.push_back(tgt_t'{we: 1'b0, adr: ctrl[15:0], dat: data, rdata: rd});
      cw_q.push_back(cw_t'{idx: 2'd0, dat: rd});
      cw_q.push_back(cw_t'{idx: 2'd1, dat: {3'b100, ctrl[28:0]}});
   endtask

   task automatic chk_reset_outputs(input string ph);
      chk({ph, "_c_stb"}, {31'h0, bus.c_stb_o}, 32'h0);
      chk({ph, "_c_we"},  {31'h0, bus.c_we_o}, 32'h0);
      chk({ph, "_c_adr"}, {16'h0, bus.c_adr_o}, 32'h0);
      chk({ph, "_c_dat"}, bus.c_dat_o, 32'h0);
      chk({ph, "_t_stb"}, {31'h0, bus.t_stb_o}, 32'h0);
      chk({ph, "_t_we"},  {31'h0, bus.t_we_o}, 32'h0);
      chk({ph, "_t_adr"}, {16'h0, bus.t_adr_o}, 32'h0);
      chk({ph, "_t_dat"}, bus.t_dat_o, 32'h0);
      chk({ph, "_busy"},  {31'h0, busy}, 32'h0);
      chk({ph, "_err"},   {31'h0, err}, 32'h0);
      chk({ph, "_count"}, {16'h0, req_count}, 32'h0);
   endtask

   initial begin
      int base, r0, n;
      tick(3);
      chk_reset_outputs("rst");
      rst = 1'b0;

      // single write request: no converter writes expected
      post_write(32'h1234_5678, 32'h4000_0010);
      wait_count(16'd1, 200);
      wait_idle(100);
      chk("wr_tgt_drained", tgt_q.size(), 0);
      chk("wr_no_conv_wr", conv_wr_cnt, 0);

      // read request with response
      post_read(32'h0, 32'h2000_0020, 32'hCAFE_F00D);
      wait_count(16'd2, 200);
      wait_idle(100);
      chk("rd_resp_drained", cw_q.size(), 0);
      chk("rd_conv_wr_cnt", conv_wr_cnt, 2);

      // out-FIFO full holds the response back
      fifo_full = 1'b1;
      post_read(32'h5555_AAAA, 32'h2000_0030, 32'h0BAD_F00D);
      n = 0;
      while (tgt_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("fifo_tgt_done", tgt_q.size(), 0);
      base = conv_wr_cnt;
      tick(10);
      chk("fifo_hold_no_wr", conv_wr_cnt, base);
      chk("fifo_hold_busy", {31'h0, busy}, 32'h1);
      fifo_full = 1'b0;
      wait_count(16'd3, 200);
      chk("fifo_resp_drained", cw_q.size(), 0);

      // three back-to-back requests, last with both type bits set (write)
      r0 = rd_data_cnt;
      post_write(32'h1111_1111, 32'h4000_0100);
      post_read(32'h2222_2222, 32'h2000_0200, 32'h3333_3333);
      post_write(32'h4444_4444, 32'h6000_0300);
      n = 0;
      while (rd_data_cnt == r0 && n < 200) begin @(negedge clk); n++; end
      saw_idle = 1'b0;
      wait_count(16'd6, 400);
      chk("b2b_no_idle", {31'h0, saw_idle}, 32'h0);
      wait_idle(100);
      chk("b2b_tgt_drained", tgt_q.size(), 0);
      chk("b2b_resp_drained", cw_q.size(), 0);

      // neither type bit: counted, no target access
      pend_q.push_back(req_t'{data: 32'h9999_9999, ctrl: 32'h0000_0400});
      wait_count(16'd7, 200);
      wait_idle(100);
      chk("none_pend_drained", pend_q.size(), 0);

`ifdef PCIE_WB_SEQ_TIMEOUT_EN
      tgt_ack_en = 1'b0;
      pend_q.push_back(req_t'{data: 32'h0, ctrl: 32'h2000_0040});
      cw_q.push_back(cw_t'{idx: 2'd0, dat: 32'hDEAD_BEEF});
      cw_q.push_back(cw_t'{idx: 2'd1, dat: 32'h8000_0040});
      wait_count(16'd8, 300);
      chk("tmo_stb_len", tstb_last, TO);
      chk("tmo_err", {31'h0, err}, 32'h1);
      wait_idle(100);
      chk("tmo_resp_drained", cw_q.size(), 0);
      tgt_ack_en = 1'b1;
`else
      chk("tmo_err_tied", {31'h0, err}, 32'h0);
`endif

      // reset in the middle of EXEC
      tgt_ack_en = 1'b0;
      post_write(32'h7777_7777, 32'h4000_0500);
      n = 0;
      while (bus.t_stb_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("exec_reached", {31'h0, bus.t_stb_o}, 32'h1);
      rst = 1'b1;
      tick(1);
      chk_reset_outputs("midrst");
      rst = 1'b0;
      tgt_q.delete();
      tgt_ack_en = 1'b1;
      n = 0;
      while (bus.c_stb_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("poll_resume_cycles", n, PI + 2);
      chk("poll_resume_adr", {16'h0, bus.c_adr_o}, {16'h0, BASE | 16'h000C});
      wait_idle(100);
      chk("lost_req_count", {16'h0, req_count}, 32'h0);
      chk("lost_req_pend", pend_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
